riscv_run_monitor: RTL and testbench
====================================

# riscv_run_monitor

Synthesizable run controller and register-dump engine for the single-cycle RISC-V core on the FPGA build. It holds the core in reset for a programmable number of cycles and then lets it execute for a bounded number of cycles. Execution stops early on `ebreak` or on a jump-to-self. The block then stalls the core and streams every architectural register out over a valid/ready port. This replaces the fixed-cycle, simulation-only register print with hardware usable on the board and in self-checking benches.

## Interface
- `XLEN`, 32, data width of registers, PC and instruction.
- `NUM_REGS`, 32, number of registers dumped; index width `IW = $clog2(NUM_REGS)`.
- `RESET_CYCLES`, 2, cycles `core_reset` is held after `reset` deasserts; must be ≥1.
- `RUN_CYCLES`, 32, maximum cycles with `core_en=1`; 0 is legal.
- `HALT_ON_EBREAK`, 1, enables early stop on `ebreak`.
- `HALT_ON_SELFLOOP`, 1, enables early stop on `jal x0,0`.

Ports (clock and reset first):
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `PC_I` in XLEN: current core PC (informational; latched at halt).
- `Instr_I` in XLEN: instruction the core executes this cycle.
- `core_reset` out 1: reset to the core.
- `core_en` out 1: core clock enable; 0 freezes PC and register file.
- `rf_raddr` out IW: debug read address into the core register file.
- `rf_rdata` in XLEN: combinational read data for `rf_raddr`.
- `dump_valid` out 1: a dump word is offered.
- `dump_ready` in 1: the consumer accepts the word.
- `dump_idx` out IW: register index of the offered word.
- `dump_data` out XLEN: register value (equals `rf_rdata`).
- `done` out 1: the dump is complete.
- `halt_cause` out 2: 0 none, 1 cycle limit, 2 ebreak, 3 self-loop.
- `halt_pc` out XLEN: PC latched on the halting cycle.
- `cycles_run` out 32: number of cycles with `core_en=1`.

## Operation
- FSM states: HOLD → RUN → DUMP → DONE. All outputs are Moore, decoded from state and registers.
- Reset values: state=HOLD, `core_reset=1`, `core_en=0`, `dump_valid=0`, `done=0`, `halt_cause=0`, `halt_pc=0`, `cycles_run=0`, index=0.
- **HOLD:** `core_reset=1`. A counter runs for `RESET_CYCLES` cycles. Exit goes to RUN, or to DUMP with cause 1 if `RUN_CYCLES==0`.
- **RUN:** `core_reset=0`, `core_en=1`, `cycles_run` increments every cycle. Halt checks, in priority order:
  - `Instr_I==32'h00100073` with `HALT_ON_EBREAK` → cause 2.
  - `Instr_I==32'h0000006F` with `HALT_ON_SELFLOOP` → cause 3.
  - `cycles_run+1==RUN_CYCLES` → cause 1.
  - On any halt: latch `PC_I` into `halt_pc`, go to DUMP. The halting instruction retires, because its edge still has `core_en=1`.
- **DUMP:** `core_en=0`, `dump_valid=1`, `rf_raddr=dump_idx=index`, `dump_data=rf_rdata`.
  - On `dump_valid&&dump_ready` the index increments.
  - Acceptance at index `NUM_REGS-1` → DONE.
  - While `dump_ready=0`, index and data hold stable.
- **DONE:** `done=1`, `core_en=0`, `dump_valid=0`. The block stays here until `reset`.
- `cycles_run` saturates at 2^32−1.
- `reset` in any state returns to HOLD next edge with all reset values, aborting a run or dump mid-stream.

## Timing
- `core_reset` falls exactly `RESET_CYCLES` edges after the first edge with `reset=0`. `core_en` rises on the same edge.
- Cycle-limit halt: exactly `RUN_CYCLES` edges have `core_en=1`.
- Early halt: `core_en` falls on the edge after the matching `Instr_I` is seen.
- DUMP has zero-latency data: the word is valid in the same cycle as its index. With `dump_ready` held high, one word transfers per cycle and `NUM_REGS` cycles elapse from DUMP entry to DONE.

## Structure
- Package `riscv_mon_pkg` holds:
  - the state enum (HOLD/RUN/DUMP/DONE);
  - constants `INSTR_EBREAK=32'h00100073` and `INSTR_JAL_SELF=32'h0000006F`;
  - the halt-cause codes.
- Single module, one FSM plus three counters (hold, run, dump index). No sub-module is warranted.

## Test plan
- Defaults, program with no halt, `dump_ready=1` → `core_reset` high for 2 cycles, `core_en` high for exactly 32, `halt_cause=1`, `cycles_run=32`, 32 words with idx 0..31 on consecutive cycles, then `done=1`.
- `ebreak` fetched at PC 0x14 (6th instruction) → `core_en` drops after 6 cycles, `halt_cause=2`, `halt_pc=0x14`, `cycles_run=6`.
- `jal x0,0` at PC 0x20 → `halt_cause=3`, `halt_pc=0x20`. With `HALT_ON_SELFLOOP=0`, the run instead ends at 32 cycles with cause 1.
- `dump_ready` toggling 1,0,0,1… → index advances only on accepted cycles, `dump_data`/`dump_idx` are stable across stalls, and the x5 word equals the register value (e.g. 5 after `addi x5,x0,5`).
- `RUN_CYCLES=0` → HOLD goes directly to DUMP, `cycles_run=0`, `halt_cause=1`, all registers read 0.
- `reset` asserted mid-DUMP at idx 10 → next cycle HOLD, `done=0`, `dump_valid=0`, counters 0, and a full sequence repeats.

Source files
------------

// File: rtl/riscv_mon_pkg.sv
// Shared types and constants for the RISC-V run controller / register-dump engine.
package riscv_mon_pkg;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DUMP = 2'd2,
        ST_DONE = 2'd3
    } mon_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_LIMIT    = 2'd1,
        CAUSE_EBREAK   = 2'd2,
        CAUSE_SELFLOOP = 2'd3
    } halt_cause_e;

    localparam logic [31:0] INSTR_EBREAK   = 32'h0010_0073;
    localparam logic [31:0] INSTR_JAL_SELF = 32'h0000_006F;

endpackage

// File: rtl/riscv_run_monitor.sv
// Holds the core in reset, runs it for a bounded/early-halted interval, then streams
// every register out over valid/ready. Dump data is zero-latency; stalls hold idx/data.
module riscv_run_monitor
    import riscv_mon_pkg::*;
#(
    parameter int unsigned XLEN             = 32,
    parameter int unsigned NUM_REGS         = 32,
    parameter int unsigned RESET_CYCLES     = 2,
    parameter int unsigned RUN_CYCLES       = 32,
    parameter bit          HALT_ON_EBREAK   = 1'b1,
    parameter bit          HALT_ON_SELFLOOP = 1'b1,
    localparam int unsigned IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] PC_I,
    input  logic [XLEN-1:0] Instr_I,
    output logic            core_reset,
    output logic            core_en,
    output logic [IW-1:0]   rf_raddr,
    input  logic [XLEN-1:0] rf_rdata,
    output logic            dump_valid,
    input  logic            dump_ready,
    output logic [IW-1:0]   dump_idx,
    output logic [XLEN-1:0] dump_data,
    output logic            done,
    output logic [1:0]      halt_cause,
    output logic [XLEN-1:0] halt_pc,
    output logic [31:0]     cycles_run
);

    mon_state_e      state_q, state_d;
    logic [31:0]     hold_q, hold_d;
    logic [31:0]     cyc_q, cyc_d;
    logic [IW-1:0]   idx_q, idx_d;
    halt_cause_e     cause_q, cause_d;
    logic [XLEN-1:0] hpc_q, hpc_d;

    logic hold_exit, hit_ebreak, hit_self, hit_limit, halt, last_acc;

    assign hold_exit  = (hold_q == 32'(RESET_CYCLES - 1));
    assign hit_ebreak = HALT_ON_EBREAK   && (Instr_I == XLEN'(INSTR_EBREAK));
    assign hit_self   = HALT_ON_SELFLOOP && (Instr_I == XLEN'(INSTR_JAL_SELF));
    // 33-bit compare so RUN_CYCLES near 2^32 cannot wrap the limit check.
    assign hit_limit  = (({1'b0, cyc_q} + 33'd1) == 33'(RUN_CYCLES));
    assign halt       = hit_ebreak || hit_self || hit_limit;
    assign last_acc   = dump_ready && (idx_q == IW'(NUM_REGS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HOLD: if (hold_exit) state_d = (RUN_CYCLES == 0) ? ST_DUMP : ST_RUN;
            ST_RUN:  if (halt)      state_d = ST_DUMP;
            ST_DUMP: if (last_acc)  state_d = ST_DONE;
            default: state_d = ST_DONE;
        endcase
    end

    always_comb begin
        core_reset = 1'b0;
        core_en    = 1'b0;
        dump_valid = 1'b0;
        done       = 1'b0;
        case (state_q)
            ST_HOLD: core_reset = 1'b1;
            ST_RUN:  core_en    = 1'b1;
            ST_DUMP: dump_valid = 1'b1;
            default: done       = 1'b1;
        endcase
    end

    assign rf_raddr   = idx_q;
    assign dump_idx   = idx_q;
    assign dump_data  = rf_rdata;
    assign halt_cause = cause_q;
    assign halt_pc    = hpc_q;
    assign cycles_run = cyc_q;

    always_comb begin
        hold_d  = hold_q;
        cyc_d   = cyc_q;
        idx_d   = idx_q;
        cause_d = cause_q;
        hpc_d   = hpc_q;
        case (state_q)
            ST_HOLD: begin
                if (!hold_exit) hold_d = hold_q + 32'd1;
                else if (RUN_CYCLES == 0) cause_d = CAUSE_LIMIT;
            end
            ST_RUN: begin
                if (cyc_q != 32'hFFFF_FFFF) cyc_d = cyc_q + 32'd1;
                if (halt) begin
                    hpc_d = PC_I;
                    if (hit_ebreak)    cause_d = CAUSE_EBREAK;
                    else if (hit_self) cause_d = CAUSE_SELFLOOP;
                    else               cause_d = CAUSE_LIMIT;
                end
            end
            ST_DUMP: if (dump_ready && !last_acc) idx_d = idx_q + IW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q  <= '0;
            cyc_q   <= '0;
            idx_q   <= '0;
            cause_q <= CAUSE_NONE;
            hpc_q   <= '0;
        end else begin
            hold_q  <= hold_d;
            cyc_q   <= cyc_d;
            idx_q   <= idx_d;
            cause_q <= cause_d;
            hpc_q   <= hpc_d;
        end
    end

endmodule

// File: tb/tb_riscv_run_monitor.sv
// Bench: three monitor configurations, each driving a tiny behavioural core and
// scoreboarding the register dump against a program-level interpreter.
module tb_riscv_run_monitor;
    import riscv_mon_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    for (genvar c = 0; c < 3; c++) begin : g
        localparam int RC = (c == 2) ? 0 : 32;
        localparam bit SL = (c == 1) ? 1'b0 : 1'b1;

        logic        reset = 1'b1;
        logic        dump_ready = 1'b0;
        logic [31:0] PC_I, Instr_I, rf_rdata, halt_pc, cycles_run, dump_data;
        logic [4:0]  rf_raddr, dump_idx;
        logic        core_reset, core_en, dump_valid, done;
        logic [1:0]  halt_cause;
        bit          fin = 1'b0;

        riscv_run_monitor #(.RUN_CYCLES(RC), .HALT_ON_SELFLOOP(SL)) dut (
            .clk(clk), .reset(reset), .PC_I(PC_I), .Instr_I(Instr_I),
            .core_reset(core_reset), .core_en(core_en), .rf_raddr(rf_raddr),
            .rf_rdata(rf_rdata), .dump_valid(dump_valid), .dump_ready(dump_ready),
            .dump_idx(dump_idx), .dump_data(dump_data), .done(done),
            .halt_cause(halt_cause), .halt_pc(halt_pc), .cycles_run(cycles_run)
        );

        // Minimal core: addi, jal x0,0 (PC holds), everything else a nop.
        logic [31:0] imem [64];
        logic [31:0] regs [32];
        logic [31:0] pc = 32'd0;
        assign PC_I     = pc;
        assign Instr_I  = imem[pc[7:2]];
        assign rf_rdata = regs[rf_raddr];

        always @(posedge clk) begin
            if (core_reset) begin
                pc <= 32'd0;
                for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
            end else if (core_en) begin
                if (Instr_I[6:0] == 7'h13 && Instr_I[11:7] != 5'd0)
                    regs[Instr_I[11:7]] <= regs[Instr_I[19:15]] + {{20{Instr_I[31]}}, Instr_I[31:20]};
                if (Instr_I != INSTR_JAL_SELF) pc <= pc + 32'd4;
            end
        end

        logic [36:0] expq [$];
        int en_cnt, rst_cnt, dv_cnt;
        bit stall_p;
        logic [36:0] stall_w, popw;

        initial begin
            en_cnt = 0; rst_cnt = 0; dv_cnt = 0; stall_p = 0;
            forever begin
                @(negedge clk);
                if (reset) begin
                    en_cnt = 0; rst_cnt = 0; dv_cnt = 0; stall_p = 0;
                end else begin
                    if (core_reset) rst_cnt++;
                    if (core_en) en_cnt++;
                    if (dump_valid) begin
                        dv_cnt++;
                        if (stall_p) chk($sformatf("c%0d stall hold", c), 64'({dump_idx, dump_data}), 64'(stall_w));
                        if (dump_ready) begin
                            stall_p = 0;
                            if (expq.size() == 0) chk($sformatf("c%0d extra word", c), 64'(dump_idx), 64'hFFFF);
                            else begin
                                popw = expq.pop_front();
                                chk($sformatf("c%0d word", c), 64'({dump_idx, dump_data}), 64'(popw));
                            end
                        end else begin
                            stall_p = 1;
                            stall_w = {dump_idx, dump_data};
                        end
                    end else stall_p = 0;
                end
            end
        end

        int          m_n;
        logic [1:0]  m_cause;
        logic [31:0] m_pc;

        // Program-level interpreter: straight-line code, one instruction per run cycle.
        task automatic model();
            logic [31:0] m [32];
            logic [31:0] ins;
            int p = 0;
            bit stop = 0;
            for (int i = 0; i < 32; i++) m[i] = 32'd0;
            m_n = 0; m_cause = 2'd1; m_pc = 32'd0;
            for (int k = 0; k < RC && !stop; k++) begin
                ins = imem[p];
                m_n++;
                if (ins[6:0] == 7'h13 && ins[11:7] != 5'd0)
                    m[ins[11:7]] = m[ins[19:15]] + {{20{ins[31]}}, ins[31:20]};
                if (ins == INSTR_EBREAK) begin
                    m_cause = 2'd2; m_pc = 32'(p * 4); stop = 1;
                end else if (ins == INSTR_JAL_SELF && SL) begin
                    m_cause = 2'd3; m_pc = 32'(p * 4); stop = 1;
                end else if (m_n == RC) begin
                    m_cause = 2'd1; m_pc = 32'(p * 4); stop = 1;
                end
                if (ins != INSTR_JAL_SELF) p++;
            end
            for (int i = 0; i < 32; i++) expq.push_back({5'(i), m[i]});
        endtask

        task automatic check_reset_state(input string tag);
            chk({tag, " core_reset"}, 64'(core_reset), 64'd1);
            chk({tag, " core_en"},    64'(core_en), 64'd0);
            chk({tag, " dump_valid"}, 64'(dump_valid), 64'd0);
            chk({tag, " done"},       64'(done), 64'd0);
            chk({tag, " cause/pc/cyc/idx"}, 64'({halt_cause, halt_pc, cycles_run[24:0], dump_idx}), 64'd0);
        endtask

        // kind: 0 plain, 1 ebreak at pos, 2 self-loop at pos; rmode: 0 ready=1, 1 1,0,0 pattern, 2 random.
        task automatic run(input int kind, input int pos, input int rmode, input bit abort, input bit newprog);
            int cyc = 0;
            bit aborted = 0;
            if (newprog) begin
                imem[0] = {12'd5, 5'd0, 3'b000, 5'd5, 7'h13};
                for (int i = 1; i < 64; i++)
                    imem[i] = {12'($urandom_range(0, 4095)), 5'($urandom_range(0, 31)), 3'b000,
                               5'($urandom_range(6, 31)), 7'h13};
                if (kind == 1) imem[pos] = INSTR_EBREAK;
                if (kind == 2) imem[pos] = INSTR_JAL_SELF;
            end
            reset = 1'b1; dump_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            expq.delete();
            model();
            check_reset_state($sformatf("c%0d reset", c));
            reset = 1'b0;
            while (!done && cyc < 600 && !aborted) begin
                case (rmode)
                    0:       dump_ready = 1'b1;
                    1:       dump_ready = (cyc % 3 == 0);
                    default: dump_ready = 1'($urandom_range(0, 1));
                endcase
                @(posedge clk); #1;
                cyc++;
                if (abort && dump_valid && dump_idx == 5'd10) begin
                    reset = 1'b1; dump_ready = 1'b0;
                    @(posedge clk); #1;
                    check_reset_state($sformatf("c%0d abort", c));
                    aborted = 1;
                end
            end
            if (!aborted) begin
                chk($sformatf("c%0d done reached", c), 64'(done), 64'd1);
                chk($sformatf("c%0d halt_cause", c), 64'(halt_cause), 64'(m_cause));
                chk($sformatf("c%0d halt_pc", c), 64'(halt_pc), 64'(m_pc));
                chk($sformatf("c%0d cycles_run", c), 64'(cycles_run), 64'(m_n));
                chk($sformatf("c%0d core_en cycles", c), 64'(en_cnt), 64'(m_n));
                chk($sformatf("c%0d core_reset cycles", c), 64'(rst_cnt), 64'd2);
                chk($sformatf("c%0d words left", c), 64'(expq.size()), 64'd0);
                if (rmode == 0) chk($sformatf("c%0d dump cycles", c), 64'(dv_cnt), 64'd32);
                repeat (3) @(posedge clk);
                #1;
                chk($sformatf("c%0d done sticky", c), 64'({done, dump_valid, core_en}), 64'b100);
            end
        endtask

        initial begin
            run(0, 0, 0, 0, 1);
            run(1, 5, 0, 0, 1);
            run(2, 8, 1, 0, 1);
            for (int t = 0; t < 3; t++)
                run($urandom_range(0, 2), $urandom_range(1, 40), 2, 0, 1);
            run(0, 0, 0, 1, 1);
            run(0, 0, 0, 0, 0);
            fin = 1'b1;
        end
    end

    initial begin
        int w = 0;
        while (!(g[0].fin && g[1].fin && g[2].fin) && w < 60000) begin
            @(posedge clk);
            w++;
        end
        if (!(g[0].fin && g[1].fin && g[2].fin)) begin
            total++;
            bad++;
            $display("FAIL global timeout: got %0d cycles, expected completion", w);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
